// File: rtl/wash_sequencer.sv
// wash_sequencer: programmable multi-round fill/agitate/drain washer with final spin.
// In: clk, rst_n, start, pause, abort. Out: ctrl_fill, ctrl_release, ctrl_forward,
// ctrl_reverse, busy, done, phase[2:0], round[3:0]. LEVEL_SENSOR_EN adds water_full, fault.
module wash_sequencer #(
  parameter int TW          = 16,
  parameter int ROUNDS      = 3,
  parameter int FILL_TICKS  = 40,
  parameter int WASH_TICKS  = 300,
  parameter int RINSE_TICKS = 150,
  parameter int DIR_TICKS   = 20,
  parameter int GAP_TICKS   = 5,
  parameter int DRAIN_TICKS = 30,
  parameter int SPIN_TICKS  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
`ifdef LEVEL_SENSOR_EN
  input  logic       water_full,
  output logic       fault,
`endif
  output logic       ctrl_fill,
  output logic       ctrl_release,
  output logic       ctrl_forward,
  output logic       ctrl_reverse,
  output logic       busy,
  output logic       done,
  output logic [2:0] phase,
  output logic [3:0] round
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_AGIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  // Pattern counter spans two directions plus two gaps.
  localparam int PW = TW + 2;

  localparam logic [TW-1:0] L_FILL  = TW'(FILL_TICKS - 1);
  localparam logic [TW-1:0] L_WASH  = TW'(WASH_TICKS - 1);
  localparam logic [TW-1:0] L_RINSE = TW'(RINSE_TICKS - 1);
  localparam logic [TW-1:0] L_DRAIN = TW'(DRAIN_TICKS - 1);
  localparam logic [TW-1:0] L_SPIN  = TW'(SPIN_TICKS - 1);

  localparam logic [PW-1:0] L_DIR  = PW'(DIR_TICKS);
  localparam logic [PW-1:0] L_REV0 = PW'(DIR_TICKS + GAP_TICKS);
  localparam logic [PW-1:0] L_REV1 = PW'(2 * DIR_TICKS + GAP_TICKS);
  localparam logic [PW-1:0] L_PEND = PW'(2 * (DIR_TICKS + GAP_TICKS) - 1);
  localparam logic [3:0]    L_LAST = 4'(ROUNDS - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_pat;
  logic [3:0]    r_round;

  logic r_fill;
  logic r_rel;
  logic r_fwd;
  logic r_rev;
  logic r_busy;
  logic r_done;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [PW-1:0] w_pat_nxt;
  logic [3:0]    w_round_nxt;
  logic          w_done_nxt;

  logic w_fill_nxt;
  logic w_rel_nxt;
  logic w_fwd_nxt;
  logic w_rev_nxt;
  logic w_busy_nxt;

  logic          w_expire;
  logic          w_abort_go;
  logic          w_hold;
  logic [TW-1:0] w_agit_len;

`ifdef LEVEL_SENSOR_EN
  logic r_wf;
  logic r_fault;
  logic w_fault_nxt;
`endif

  assign w_expire   = (r_timer == '0);
  // A running abort drain is not restarted by abort staying high.
  assign w_abort_go = abort && (r_state != S_IDLE)
                      && (r_state != S_ABORT);
  assign w_hold     = pause && (r_state != S_IDLE)
                      && !w_abort_go;
  assign w_agit_len = (r_round == 4'd0) ? L_WASH : L_RINSE;

  // State and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pat   <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pat   <= w_pat_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pat_nxt   = r_pat;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
`ifdef LEVEL_SENSOR_EN
    w_fault_nxt = r_fault;
`endif
    if (r_state == S_IDLE) begin
      if (start && !abort) begin
        w_state_nxt = S_FILL;
        w_timer_nxt = L_FILL;
        w_round_nxt = '0;
`ifdef LEVEL_SENSOR_EN
        w_fault_nxt = 1'b0;
`endif
      end
    end else if (w_abort_go) begin
      w_state_nxt = S_ABORT;
      w_timer_nxt = L_DRAIN;
      w_round_nxt = '0;
    end else if (!w_hold) begin
      unique case (r_state)
        S_FILL: begin
`ifdef LEVEL_SENSOR_EN
          if (r_wf) begin
            w_state_nxt = S_AGIT;
            w_timer_nxt = w_agit_len;
            w_pat_nxt   = '0;
          end else if (w_expire) begin
            w_state_nxt = S_ABORT;
            w_timer_nxt = L_DRAIN;
            w_round_nxt = '0;
            w_fault_nxt = 1'b1;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
`else
          if (w_expire) begin
            w_state_nxt = S_AGIT;
            w_timer_nxt = w_agit_len;
            w_pat_nxt   = '0;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
`endif
        end
        S_AGIT: begin
          if (w_expire) begin
            w_state_nxt = S_DRAIN;
            w_timer_nxt = L_DRAIN;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
            w_pat_nxt   = (r_pat == L_PEND) ?
                          '0 : r_pat + PW'(1);
          end
        end
        S_DRAIN: begin
          if (w_expire) begin
            if (r_round < L_LAST) begin
              w_state_nxt = S_FILL;
              w_timer_nxt = L_FILL;
              w_round_nxt = r_round + 4'd1;
            end else begin
              w_state_nxt = S_SPIN;
              w_timer_nxt = L_SPIN;
            end
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        S_SPIN: begin
          if (w_expire) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        S_ABORT: begin
          if (w_expire) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_round_nxt = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the upcoming state so they can be registered
  always_comb begin
    w_fill_nxt = 1'b0;
    w_rel_nxt  = 1'b0;
    w_fwd_nxt  = 1'b0;
    w_rev_nxt  = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (!w_hold) begin
      unique case (w_state_nxt)
        S_FILL: w_fill_nxt = 1'b1;
        S_AGIT: begin
          w_fwd_nxt = (w_pat_nxt < L_DIR);
          w_rev_nxt = (w_pat_nxt >= L_REV0)
                      && (w_pat_nxt < L_REV1);
        end
        S_DRAIN, S_ABORT: w_rel_nxt = 1'b1;
        S_SPIN: begin
          w_rel_nxt = 1'b1;
          w_fwd_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 1'b0;
      r_rel  <= 1'b0;
      r_fwd  <= 1'b0;
      r_rev  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fill <= w_fill_nxt;
      r_rel  <= w_rel_nxt;
      r_fwd  <= w_fwd_nxt;
      r_rev  <= w_rev_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

`ifdef LEVEL_SENSOR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wf    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_wf    <= water_full;
      r_fault <= w_fault_nxt;
    end
  end

  assign fault = r_fault;
`endif

  assign ctrl_fill    = r_fill;
  assign ctrl_release = r_rel;
  assign ctrl_forward = r_fwd;
  assign ctrl_reverse = r_rev;
  assign busy         = r_busy;
  assign done         = r_done;
  assign phase        = r_state;
  assign round        = r_round;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: vector table, directed corner sequences and
// randomized stimulus against a per-cycle schedule model.
module tb_wash_sequencer;

  localparam int FILL   = 4;
  localparam int WASH   = 12;
  localparam int RINSE  = 6;
  localparam int DIR    = 2;
  localparam int GAP    = 1;
  localparam int DRAIN  = 3;
  localparam int SPIN   = 5;
  localparam int ROUNDS = 2;
  localparam int NV     = 23;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       abort;
  logic       ctrl_fill;
  logic       ctrl_release;
  logic       ctrl_forward;
  logic       ctrl_reverse;
  logic       busy;
  logic       done;
  logic [2:0] phase;
  logic [3:0] round;
`ifdef LEVEL_SENSOR_EN
  logic       water_full;
  logic       fault;
`endif

  wash_sequencer #(
    .TW(16), .ROUNDS(ROUNDS), .FILL_TICKS(FILL),
    .WASH_TICKS(WASH), .RINSE_TICKS(RINSE),
    .DIR_TICKS(DIR), .GAP_TICKS(GAP),
    .DRAIN_TICKS(DRAIN), .SPIN_TICKS(SPIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .abort(abort),
`ifdef LEVEL_SENSOR_EN
    .water_full(water_full),
    .fault(fault),
`endif
    .ctrl_fill(ctrl_fill),
    .ctrl_release(ctrl_release),
    .ctrl_forward(ctrl_forward),
    .ctrl_reverse(ctrl_reverse),
    .busy(busy),
    .done(done),
    .phase(phase),
    .round(round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] rd;
    logic       f;
    logic       r;
    logic       fw;
    logic       rv;
    logic       dn;
  } rec_t;

  rec_t cur;
  rec_t q[$];

  typedef struct {
    bit         st;
    bit         pa;
    bit         ab;
    int         n;
    logic [2:0] ph;
    logic [3:0] rd;
    logic [3:0] ctl;
    bit         dn;
  } vec_t;

  vec_t tbl[NV];

  function automatic rec_t mk(input logic [2:0] ph,
                              input int rd, input bit f,
                              input bit r, input bit fw,
                              input bit rv);
    rec_t x;
    x.ph = ph;
    x.rd = 4'(rd);
    x.f  = f;
    x.r  = r;
    x.fw = fw;
    x.rv = rv;
    x.dn = 1'b0;
    return x;
  endfunction

  function automatic vec_t v(input bit s, input bit p,
                             input bit a, input int n,
                             input int ph, input int rd,
                             input logic [3:0] c,
                             input bit d);
    vec_t x;
    x.st  = s;
    x.pa  = p;
    x.ab  = a;
    x.n   = n;
    x.ph  = 3'(ph);
    x.rd  = 4'(rd);
    x.ctl = c;
    x.dn  = d;
    return x;
  endfunction

  // Whole program laid out cycle by cycle from the phase rules.
  task automatic load_prog();
    int len;
    int p;
    q.delete();
    for (int rd = 0; rd < ROUNDS; rd++) begin
      for (int i = 0; i < FILL; i++)
        q.push_back(mk(3'd1, rd, 1, 0, 0, 0));
      len = (rd == 0) ? WASH : RINSE;
      for (int i = 0; i < len; i++) begin
        p = i % (2 * (DIR + GAP));
        q.push_back(mk(3'd2, rd, 0, 0, p < DIR,
                       (p >= DIR + GAP) && (p < 2 * DIR + GAP)));
      end
      for (int i = 0; i < DRAIN; i++)
        q.push_back(mk(3'd3, rd, 0, 1, 0, 0));
    end
    for (int i = 0; i < SPIN; i++)
      q.push_back(mk(3'd4, ROUNDS - 1, 0, 1, 1, 0));
  endtask

  task automatic model_step();
    rec_t prev;
    prev = cur;
    if (cur.ph == 3'd0) begin
      if (start && !abort) begin
        load_prog();
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end else if (abort && cur.ph != 3'd5) begin
      q.delete();
      for (int i = 0; i < DRAIN; i++)
        q.push_back(mk(3'd5, 0, 0, 1, 0, 0));
      cur = q.pop_front();
    end else if (pause) begin
      cur.f  = 1'b0;
      cur.r  = 1'b0;
      cur.fw = 1'b0;
      cur.rv = 1'b0;
      cur.dn = 1'b0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur    = '0;
      cur.dn = (prev.ph == 3'd4);
    end
  endtask

  task automatic model_check();
    rec_t got;
    got = {phase, round, ctrl_fill, ctrl_release,
           ctrl_forward, ctrl_reverse, done};
    tests++;
    if (got !== cur || busy !== (cur.ph != 3'd0)
        || (ctrl_forward && ctrl_reverse)) begin
      fails++;
      $display("FAIL model t=%0t got=%h busy=%b exp=%h",
               $time, got, busy, cur);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               nm, $time, got, exp);
    end
  endtask

  task automatic run_program(input int pause_at,
                             input int pause_len,
                             input int restart_at,
                             output int nbusy,
                             output int ndone,
                             output int pbad);
    int k;
    nbusy = 0;
    ndone = 0;
    pbad  = 0;
    k     = 0;
    abort = 1'b0;
    while (ndone == 0 && k < 300) begin
      start = (k == 0) || (k == restart_at);
      pause = (k >= pause_at) && (k < pause_at + pause_len);
      tick();
      if (pause && (ctrl_fill || ctrl_release || ctrl_forward
                    || ctrl_reverse || phase != 3'd2))
        pbad++;
      if (busy) nbusy++;
      if (done) ndone++;
      k++;
    end
    start = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) nbusy++;
      if (done) ndone++;
    end
  endtask

  int nb;
  int nd;
  int pb;
  int guard;

  initial begin
    tbl[0]  = v(0, 0, 0, 20, 0, 0, 4'b0000, 0);
    tbl[1]  = v(0, 1, 0, 3,  0, 0, 4'b0000, 0);
    tbl[2]  = v(1, 0, 1, 2,  0, 0, 4'b0000, 0);
    tbl[3]  = v(1, 0, 0, 1,  1, 0, 4'b1000, 0);
    tbl[4]  = v(0, 0, 0, 3,  1, 0, 4'b1000, 0);
    tbl[5]  = v(0, 0, 0, 2,  2, 0, 4'b0010, 0);
    tbl[6]  = v(0, 0, 0, 1,  2, 0, 4'b0000, 0);
    tbl[7]  = v(0, 0, 0, 2,  2, 0, 4'b0001, 0);
    tbl[8]  = v(0, 0, 0, 1,  2, 0, 4'b0000, 0);
    tbl[9]  = v(0, 0, 0, 2,  2, 0, 4'b0010, 0);
    tbl[10] = v(0, 0, 0, 1,  2, 0, 4'b0000, 0);
    tbl[11] = v(0, 0, 0, 2,  2, 0, 4'b0001, 0);
    tbl[12] = v(0, 0, 0, 1,  2, 0, 4'b0000, 0);
    tbl[13] = v(0, 0, 0, 3,  3, 0, 4'b0100, 0);
    tbl[14] = v(0, 0, 0, 4,  1, 1, 4'b1000, 0);
    tbl[15] = v(0, 0, 0, 2,  2, 1, 4'b0010, 0);
    tbl[16] = v(0, 0, 0, 1,  2, 1, 4'b0000, 0);
    tbl[17] = v(0, 0, 0, 2,  2, 1, 4'b0001, 0);
    tbl[18] = v(0, 0, 0, 1,  2, 1, 4'b0000, 0);
    tbl[19] = v(0, 0, 0, 3,  3, 1, 4'b0100, 0);
    tbl[20] = v(0, 0, 0, 5,  4, 1, 4'b0110, 0);
    tbl[21] = v(0, 0, 0, 1,  0, 0, 4'b0000, 1);
    tbl[22] = v(0, 0, 0, 3,  0, 0, 4'b0000, 0);

    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
`ifdef LEVEL_SENSOR_EN
    water_full = 1'b0;
`endif
    cur = '0;
    q.delete();
    #23;
    chk("reset", {busy, done, phase, round, ctrl_fill,
                  ctrl_release, ctrl_forward, ctrl_reverse}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start = tbl[i].st;
      pause = tbl[i].pa;
      abort = tbl[i].ab;
      for (int j = 0; j < tbl[i].n; j++) begin
        tick();
        chk($sformatf("vec%0d", i),
            {phase, round, ctrl_fill, ctrl_release,
             ctrl_forward, ctrl_reverse, done, busy},
            {tbl[i].ph, tbl[i].rd, tbl[i].ctl, tbl[i].dn,
             tbl[i].ph != 3'd0});
      end
    end

    run_program(8, 10, -1, nb, nd, pb);
    chk("pause_len", nb, 37 + 10);
    chk("pause_done", nd, 1);
    chk("pause_ctrl", pb, 0);

    run_program(-1, 0, 34, nb, nd, pb);
    chk("spin_start_len", nb, 37);
    chk("spin_start_done", nd, 1);
    run_program(-1, 0, -1, nb, nd, pb);
    chk("restart_len", nb, 37);
    chk("restart_done", nd, 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 21; i++) tick();
    chk("pre_abort", {phase, round}, {3'd1, 4'd1});
    abort = 1'b1;
    tick();
    chk("abort_enter", {phase, ctrl_release, round},
        {3'd5, 1'b1, 4'd0});
    tick();
    abort = 1'b0;
    tick();
    chk("abort_hold", {phase, ctrl_release, busy},
        {3'd5, 1'b1, 1'b1});
    tick();
    chk("abort_exit", {phase, done, round, busy}, 0);
    tick();
    chk("abort_nodone", {done, busy}, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, phase, round, ctrl_fill,
                        ctrl_release, ctrl_forward,
                        ctrl_reverse}, 0);
    cur = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_reset", {busy, phase}, 0);

    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      if (pause) pause = ($urandom_range(0, 3) != 0);
      else       pause = ($urandom_range(0, 24) == 0);
      abort = ($urandom_range(0, 99) == 0);
      tick();
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    chk("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
